// File: rtl/register_file_sb_pkg.sv
// ----------------------------------------------------------------------------
// register_file_sb_pkg
// Shared defaults for the MIPS register file datapath. The register file, the
// A/B operand pipeline register and the pipeline controller all import this
// package so their widths and the $zero index stay in agreement.
//   DATA_WIDTH_DEF : default register / data-port width
//   ADDR_WIDTH_DEF : default register address width (32 registers)
//   REG_ZERO       : index of the hardwired $zero register
// ----------------------------------------------------------------------------
package register_file_sb_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int REG_ZERO       = 0;

endpackage

// File: rtl/register_file_sb_reg_scoreboard.sv
// ----------------------------------------------------------------------------
// reg_scoreboard
// Pending-write scoreboard: one busy bit per architectural register. An issuing
// instruction marks its destination busy; the matching write-back clears it.
// The lookup side reports whether either read operand still waits on a
// producer that has not written back in this cycle.
// Ports:
//   clk, rst          : clock (rising edge) and async active-low reset
//   ena               : global enable; busy bits hold when low
//   wr_ena, wr_addr   : write-back strobe and destination (clears busy)
//   alloc_ena, alloc_addr : issue strobe and destination (sets busy)
//   addr_a, addr_b    : operand addresses to look up
//   busy_a, busy_b    : operand still has an unsatisfied pending write
// ----------------------------------------------------------------------------
module reg_scoreboard
    import register_file_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  wr_ena,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  alloc_ena,
    input  logic [ADDR_WIDTH-1:0] alloc_addr,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic                  busy_a,
    output logic                  busy_b
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                wr_live;

    // A write-back only counts as resolving a hazard when it will actually
    // commit this cycle, which is also exactly when the bypass path is live.
    assign wr_live = rst & ena & wr_ena;

    // Clear first, then set, so that a fresh allocation issued in the same
    // cycle as the previous producer's write-back keeps the register busy.
    // $zero can never be pending, so its bit is forced low last.
    always_comb begin
        busy_next = busy;
        if (wr_ena)
            busy_next[wr_addr] = 1'b0;
        if (alloc_ena)
            busy_next[alloc_addr] = 1'b1;
        busy_next[REG_ZERO] = 1'b0;
    end

    // Busy bits only move while the pipeline is enabled; reset discards
    // every outstanding allocation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            busy <= '0;
        else if (ena)
            busy <= busy_next;
    end

    // An operand is only a hazard if its producer is still pending and is not
    // being written back right now (that value reaches the reader through the
    // bypass instead).
    always_comb begin
        busy_a = busy[addr_a] & ~(wr_live & (wr_addr == addr_a)) & (addr_a != ZERO_ADDR);
        busy_b = busy[addr_b] & ~(wr_live & (wr_addr == addr_b)) & (addr_b != ZERO_ADDR);
    end

endmodule

// File: rtl/register_file_sb.sv
// ----------------------------------------------------------------------------
// register_file_sb
// 32-entry MIPS general-purpose register file with two combinational read
// ports feeding the A/B operand register, one synchronous write-back port,
// write-to-read bypass, hardwired $zero and a pending-write scoreboard whose
// stall output is consumed by the pipeline controller.
// Ports:
//   clk, rst              : clock (rising edge) and async active-low reset
//   ena                   : global enable; no state changes when low
//   addr_a/addr_b         : read addresses (rs / rt)
//   data_a/data_b         : read data towards dA / dB of the operand register
//   wr_ena/wr_addr/wr_data: write-back strobe, destination and value
//   alloc_ena/alloc_addr  : issue strobe marking a destination pending
//   busy_a/busy_b         : operand waits on an unsatisfied pending write
//   stall                 : busy_a | busy_b
// ----------------------------------------------------------------------------
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b,
    input  logic                  wr_ena,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  alloc_ena,
    input  logic [ADDR_WIDTH-1:0] alloc_addr,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic                  stall
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_live;

    // The bypass is gated by reset as well as enable so that the read ports
    // show zero for the whole time reset is held, whatever the inputs do.
    assign wr_live = rst & ena & wr_ena;

    // Storage array. Entry 0 is never written, so it stays at the reset value
    // and reads of $zero are forced to zero on the read side as well.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (ena && wr_ena && (wr_addr != ZERO_ADDR)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read ports: $zero first, then the value being written back this cycle,
    // then the stored value.
    always_comb begin
        data_a = regs[addr_a];
        if (addr_a == ZERO_ADDR)
            data_a = '0;
        else if (wr_live && (wr_addr == addr_a))
            data_a = wr_data;

        data_b = regs[addr_b];
        if (addr_b == ZERO_ADDR)
            data_b = '0;
        else if (wr_live && (wr_addr == addr_b))
            data_b = wr_data;
    end

    reg_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .wr_ena     (wr_ena),
        .wr_addr    (wr_addr),
        .alloc_ena  (alloc_ena),
        .alloc_addr (alloc_addr),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .busy_a     (busy_a),
        .busy_b     (busy_b)
    );

    assign stall = busy_a | busy_b;

endmodule

// File: tb/tb_register_file_sb.sv
// ----------------------------------------------------------------------------
// tb_register_file_sb
// Bench for register_file_sb. A behavioural model (plain arrays of register
// values and pending flags) tracks what the register file must hold; a
// compare process checks every output against it on each falling edge, and
// directed steps add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_register_file_sb;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [4:0]  addr_a;
    logic [4:0]  addr_b;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        alloc_ena;
    logic [4:0]  alloc_addr;
    logic        busy_a;
    logic        busy_b;
    logic        stall;

    int checkCount = 0;
    int errorCount = 0;
    bit started    = 0;

    logic [31:0] modelReg  [32];
    bit          modelBusy [32];

    register_file_sb #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .data_a     (data_a),
        .data_b     (data_b),
        .wr_ena     (wr_ena),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_ena  (alloc_ena),
        .alloc_addr (alloc_addr),
        .busy_a     (busy_a),
        .busy_b     (busy_b),
        .stall      (stall)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the architectural state: reset empties everything; an enabled
    // edge commits a nonzero write, retires the pending flag of the written
    // register, and then records a new pending producer.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                modelReg[i]  = 32'h0;
                modelBusy[i] = 1'b0;
            end
        end else if (ena) begin
            if (wr_ena) begin
                if (wr_addr != 5'd0)
                    modelReg[wr_addr] = wr_data;
                modelBusy[wr_addr] = 1'b0;
            end
            if (alloc_ena && alloc_addr != 5'd0)
                modelBusy[alloc_addr] = 1'b1;
        end
    end

    // What a read must return: $zero, else a value committing this very
    // cycle, else what the model holds.
    function automatic logic [31:0] expData(input logic [4:0] addr);
        if (addr == 5'd0)
            return 32'h0;
        if (rst && ena && wr_ena && wr_addr == addr)
            return wr_data;
        return modelReg[addr];
    endfunction

    // An operand is a hazard when its producer is pending and not retiring now.
    function automatic logic expBusy(input logic [4:0] addr);
        if (addr == 5'd0 || !modelBusy[addr])
            return 1'b0;
        return !(rst && ena && wr_ena && wr_addr == addr);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every falling edge, check all outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("model data_a", data_a, expData(addr_a));
            checkOutput("model data_b", data_b, expData(addr_b));
            checkOutput("model busy_a", {31'b0, busy_a}, {31'b0, expBusy(addr_a)});
            checkOutput("model busy_b", {31'b0, busy_b}, {31'b0, expBusy(addr_b)});
            checkOutput("model stall", {31'b0, stall},
                        {31'b0, expBusy(addr_a) | expBusy(addr_b)});
        end
    end

    // Advance to just after the next falling edge, drive one cycle's inputs,
    // and let the combinational outputs settle before returning.
    task automatic applyStimulus(input logic en, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic ae,
                                 input logic [4:0] aa, input logic [4:0] ra,
                                 input logic [4:0] rb);
        @(negedge clk);
        #1;
        ena        = en;
        wr_ena     = we;
        wr_addr    = wa;
        wr_data    = wd;
        alloc_ena  = ae;
        alloc_addr = aa;
        addr_a     = ra;
        addr_b     = rb;
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        ena        = 1'b0;
        wr_ena     = 1'b0;
        wr_addr    = 5'd0;
        wr_data    = 32'h0;
        alloc_ena  = 1'b0;
        alloc_addr = 5'd0;
        addr_a     = 5'd0;
        addr_b     = 5'd0;
        #1;
        rst     = 1'b0;
        started = 1'b1;

        // 1. Reset with random inputs, then release and read.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1,
                          5'($urandom_range(1, 31)), 5'($urandom), 5'($urandom));
            checkOutput("reset data_a", data_a, 32'h0);
            checkOutput("reset data_b", data_b, 32'h0);
            checkOutput("reset stall", {31'b0, stall}, 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd31);
        rst = 1'b1;
        #1;
        checkOutput("release data_a", data_a, 32'h0);
        checkOutput("release data_b", data_b, 32'h0);
        checkOutput("release stall", {31'b0, stall}, 32'h0);
        applyStimulus(1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
        checkOutput("zero bypass", data_a, 32'h0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        checkOutput("zero read", data_a, 32'h0);

        // 2. Write with same-cycle read, then read back.
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 5'd3, 5'd0);
        checkOutput("bypass data_a", data_a, 32'h12345678);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
        checkOutput("stored data_a", data_a, 32'h12345678);
        checkOutput("stored data_b", data_b, 32'h12345678);

        // 3. Hazard on reg7 until its write-back.
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
        checkOutput("hazard busy_a", {31'b0, busy_a}, 32'h1);
        checkOutput("hazard stall", {31'b0, stall}, 32'h1);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
        checkOutput("hazard hold stall", {31'b0, stall}, 32'h1);
        applyStimulus(1'b1, 1'b1, 5'd7, 32'h0000CAFE, 1'b0, 5'd0, 5'd7, 5'd0);
        checkOutput("resolve busy_a", {31'b0, busy_a}, 32'h0);
        checkOutput("resolve data_a", data_a, 32'h0000CAFE);
        checkOutput("resolve stall", {31'b0, stall}, 32'h0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
        checkOutput("after busy_a", {31'b0, busy_a}, 32'h0);
        checkOutput("after data_b", data_b, 32'h0000CAFE);

        // 4. Same-cycle alloc and write-back to reg9: set wins.
        applyStimulus(1'b1, 1'b1, 5'd9, 32'h00000099, 1'b1, 5'd9, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9);
        checkOutput("setwins busy_b", {31'b0, busy_b}, 32'h1);
        checkOutput("setwins data_b", data_b, 32'h00000099);
        checkOutput("setwins stall", {31'b0, stall}, 32'h1);

        // 5. ena=0 suppresses write, alloc, clear and bypass.
        applyStimulus(1'b0, 1'b1, 5'd4, 32'h00000055, 1'b1, 5'd4, 5'd4, 5'd0);
        checkOutput("ena0 no bypass", data_a, 32'h0);
        applyStimulus(1'b0, 1'b1, 5'd9, 32'h00000077, 1'b0, 5'd0, 5'd4, 5'd9);
        checkOutput("ena0 busy_a", {31'b0, busy_a}, 32'h0);
        checkOutput("ena0 keeps busy_b", {31'b0, busy_b}, 32'h1);
        checkOutput("ena0 data_b", data_b, 32'h00000099);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9);
        checkOutput("ena0 reg4", data_a, 32'h0);
        checkOutput("ena0 busy_b after", {31'b0, busy_b}, 32'h1);

        // 6. Async reset mid-operation.
        applyStimulus(1'b1, 1'b1, 5'd1, 32'h00000011, 1'b0, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b1, 5'd2, 32'h00000022, 1'b1, 5'd2, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd1);
        checkOutput("pre-reset busy_a", {31'b0, busy_a}, 32'h1);
        checkOutput("pre-reset data_b", data_b, 32'h00000011);
        rst = 1'b0;
        #1;
        checkOutput("midreset data_a", data_a, 32'h0);
        checkOutput("midreset data_b", data_b, 32'h0);
        checkOutput("midreset busy_a", {31'b0, busy_a}, 32'h0);
        checkOutput("midreset stall", {31'b0, stall}, 32'h0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd2);
        rst = 1'b1;
        #1;
        checkOutput("postreset reg3", data_a, 32'h0);
        checkOutput("postreset busy_b", {31'b0, busy_b}, 32'h0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd7);
        checkOutput("postreset reg9", data_a, 32'h0);
        checkOutput("postreset stall", {31'b0, stall}, 32'h0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
